// File: rtl/ili9488_init_seq.sv
// ILI9488 power-up sequencer.
// Pulses the panel hardware reset, waits for the panel to wake, then walks a
// small command/data/delay table and hands each byte to the byte writer.
// Once the end marker is reached, init_done goes high and stays high until
// the next rst_n.
module ili9488_init_seq #(
   parameter int TICKS_PER_MS = 50000,
   parameter int RST_LOW_MS   = 10,
   parameter int RST_WAIT_MS  = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic [7:0] data_out,
   output logic       cs,
   output logic       dc,
   output logic       sd,
   output logic       lcd_rst_n,
   output logic       init_done
);

   localparam int            PW          = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_MS - 1);
   localparam logic [15:0]   RST_LOW_TGT = 16'(RST_LOW_MS);
   localparam logic [15:0]   RST_WAIT_TGT = 16'(RST_WAIT_MS);

   localparam logic [1:0] T_CMD   = 2'b00;
   localparam logic [1:0] T_DATA  = 2'b01;
   localparam logic [1:0] T_DELAY = 2'b10;
   localparam logic [1:0] T_END   = 2'b11;

   typedef enum logic [2:0] {
      S_RST_LOW,
      S_RST_WAIT,
      S_FETCH,
      S_ISSUE,
      S_WAIT_DONE,
      S_DELAY,
      S_DONE
   } state_t;

   // Init table: {type, value}. Unused slots hold the end marker, so the
   // index can never run past entry 15.
   function automatic logic [9:0] rom_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_entry = {T_CMD,   8'h01};
         4'd1:    rom_entry = {T_DELAY, 8'd120};
         4'd2:    rom_entry = {T_CMD,   8'h11};
         4'd3:    rom_entry = {T_DELAY, 8'd120};
         4'd4:    rom_entry = {T_CMD,   8'h3A};
         4'd5:    rom_entry = {T_DATA,  8'h66};
         4'd6:    rom_entry = {T_CMD,   8'h36};
         4'd7:    rom_entry = {T_DATA,  8'h48};
         4'd8:    rom_entry = {T_CMD,   8'h29};
         4'd9:    rom_entry = {T_DELAY, 8'd20};
         default: rom_entry = {T_END,   8'h00};
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [3:0]    index_q, index_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   ms_q, ms_d;
   logic [7:0]    delay_ms_q, delay_ms_d;
   logic [7:0]    data_q, data_d;
   logic          dc_q, dc_d;
   logic          lcd_rst_n_q, lcd_rst_n_d;
   logic          init_done_q, init_done_d;

   logic [9:0]    rom_word;
   logic [1:0]    entry_type;
   logic [7:0]    entry_val;
   logic          timed;
   logic          ms_tick;
   logic [15:0]   ms_target;
   logic          ms_expired;
   logic          timer_clr;
   logic          cs_c;
   logic          sd_c;

   // Millisecond timebase: decode which states are timed, their length,
   // and whether the current ms is the last one of that state.
   always_comb begin
      rom_word   = rom_entry(index_q);
      entry_type = rom_word[9:8];
      entry_val  = rom_word[7:0];
      timed      = (state_q == S_RST_LOW) || (state_q == S_RST_WAIT) ||
                   (state_q == S_DELAY);
      ms_tick    = timed && (presc_q == PRESC_LAST);
      ms_target  = 16'd0;
      case (state_q)
         S_RST_LOW:  ms_target = RST_LOW_TGT;
         S_RST_WAIT: ms_target = RST_WAIT_TGT;
         S_DELAY:    ms_target = {8'd0, delay_ms_q};
         default:    ms_target = 16'd0;
      endcase
      ms_expired = ms_tick && ((ms_q + 16'd1) >= ms_target);
   end

   // Sequencer: next state, table walk and bus-side outputs.
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      delay_ms_d  = delay_ms_q;
      data_d      = data_q;
      dc_d        = dc_q;
      lcd_rst_n_d = lcd_rst_n_q;
      init_done_d = init_done_q;
      timer_clr   = 1'b0;
      cs_c        = 1'b1;
      sd_c        = 1'b0;
      case (state_q)
         S_RST_LOW: begin
            lcd_rst_n_d = 1'b0;
            if (ms_expired) begin
               state_d     = S_RST_WAIT;
               lcd_rst_n_d = 1'b1;
               timer_clr   = 1'b1;
            end
         end
         S_RST_WAIT: begin
            if (ms_expired) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            case (entry_type)
               T_CMD, T_DATA: begin
                  data_d  = entry_val;
                  dc_d    = entry_type[0];
                  state_d = S_ISSUE;
               end
               T_DELAY: begin
                  if (entry_val != 8'd0) begin
                     delay_ms_d = entry_val;
                     timer_clr  = 1'b1;
                     state_d    = S_DELAY;
                  end else begin
                     index_d = index_q + 4'd1;
                  end
               end
               default: begin
                  state_d     = S_DONE;
                  init_done_d = 1'b1;
               end
            endcase
         end
         S_ISSUE: begin
            cs_c = 1'b0;
            if (!tx_busy) begin
               sd_c    = 1'b1;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            cs_c = 1'b0;
            if (tx_done) begin
               index_d = index_q + 4'd1;
               state_d = S_FETCH;
            end
         end
         S_DELAY: begin
            if (ms_expired) begin
               index_d = index_q + 4'd1;
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            init_done_d = 1'b1;
         end
         default: begin
            state_d = S_RST_LOW;
         end
      endcase
   end

   // Prescaler and ms counter: restart on entry to a timed state, idle at
   // zero everywhere else.
   always_comb begin
      presc_d = '0;
      ms_d    = 16'd0;
      if (timer_clr) begin
         presc_d = '0;
         ms_d    = 16'd0;
      end else if (timed) begin
         presc_d = ms_tick ? '0 : presc_q + 1'b1;
         ms_d    = ms_tick ? ms_q + 16'd1 : ms_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RST_LOW;
         index_q     <= 4'd0;
         presc_q     <= '0;
         ms_q        <= 16'd0;
         delay_ms_q  <= 8'd0;
         data_q      <= 8'd0;
         dc_q        <= 1'b0;
         lcd_rst_n_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         presc_q     <= presc_d;
         ms_q        <= ms_d;
         delay_ms_q  <= delay_ms_d;
         data_q      <= data_d;
         dc_q        <= dc_d;
         lcd_rst_n_q <= lcd_rst_n_d;
         init_done_q <= init_done_d;
      end
   end

   assign data_out  = data_q;
   assign dc        = dc_q;
   assign cs        = cs_c;
   assign sd        = sd_c;
   assign lcd_rst_n = lcd_rst_n_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_ili9488_init_seq.sv
// Bench for ili9488_init_seq: byte-writer model, randomized spurious pulses,
// backpressure and reset points, checked against a table-level model.
module tb_ili9488_init_seq;

   localparam int TPM  = 4;
   localparam int RLMS = 10;
   localparam int RWMS = 120;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_busy = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] data_out;
   logic       cs;
   logic       dc;
   logic       sd;
   logic       lcd_rst_n;
   logic       init_done;

   ili9488_init_seq #(
      .TICKS_PER_MS (TPM),
      .RST_LOW_MS   (RLMS),
      .RST_WAIT_MS  (RWMS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .data_out  (data_out),
      .cs        (cs),
      .dc        (dc),
      .sd        (sd),
      .lcd_rst_n (lcd_rst_n),
      .init_done (init_done)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      logic       dc;
      int         gap_ms;
   } exp_t;

   typedef struct {
      logic [7:0] b;
      logic       dc;
      logic       cs;
      int         cyc;
   } rec_t;

   logic [9:0] tbl [0:15];
   exp_t       exp_q[$];
   rec_t       log_q[$];
   int         done_ms;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int last_done_cyc = 0;
   int wr_lat = 5;
   int wr_cnt = 0;
   logic busy_w = 1'b0;
   logic hold_busy = 1'b0;
   logic inject_done = 1'b0;
   logic sd_prev = 1'b0;
   logic rstn_hi_seen = 1'b0;
   int viol_sd = 0;
   int viol_rst = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
   endtask

   task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
      n_checks++;
      assert (obs >= lo && obs <= hi) n_pass++;
      else $error("[TB] FAIL %s: observed %0d, required %0d..%0d", tag, obs, lo, hi);
   endtask

   // One clock cycle: drive inputs 1 after the edge (writer model, forced
   // busy, spurious done), then sample outputs 2 after the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      cyc++;
      tx_done = 1'b0;
      if (sd_prev) begin
         busy_w = 1'b1;
         wr_cnt = 1;
      end else if (wr_cnt != 0) begin
         wr_cnt++;
      end
      if (wr_cnt != 0 && wr_cnt == wr_lat) begin
         tx_done       = 1'b1;
         busy_w        = 1'b0;
         wr_cnt        = 0;
         last_done_cyc = cyc;
      end
      if (inject_done) tx_done = 1'b1;
      tx_busy = busy_w | hold_busy;
      #1;
      if (sd === 1'b1) begin
         if (tx_busy) viol_sd++;
         if (sd_prev) viol_sd++;
         log_q.push_back('{data_out, dc, cs, cyc});
      end
      if (lcd_rst_n === 1'b1) rstn_hi_seen = 1'b1;
      else if (rstn_hi_seen) viol_rst++;
      sd_prev = sd;
   endtask

   task automatic checkReset(input string tag);
      checkOutput(tag, {19'd0, data_out, cs, dc, sd, lcd_rst_n, init_done},
                  {19'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic resetDut(input string tag);
      rst_n        = 1'b0;
      wr_cnt       = 0;
      busy_w       = 1'b0;
      hold_busy    = 1'b0;
      inject_done  = 1'b0;
      tx_busy      = 1'b0;
      tx_done      = 1'b0;
      sd_prev      = 1'b0;
      rstn_hi_seen = 1'b0;
      #1;
      checkReset(tag);
      log_q.delete();
      repeat (2) applyStimulus();
   endtask

   // Releases rst_n between edges and returns the number of edges until
   // lcd_rst_n is seen high.
   task automatic releaseReset(output int n);
      #1;
      rst_n = 1'b1;
      applyStimulus();
      checkReset("reset_release_cycle");
      n = 1;
      while (lcd_rst_n !== 1'b1 && n < 200) begin
         applyStimulus();
         n++;
      end
      rise_cyc = cyc;
   endtask

   task automatic waitLog(input int n, input string tag);
      int g = 0;
      while (log_q.size() < n && g < 2000) begin
         applyStimulus();
         g++;
      end
      checkOutput(tag, 32'(log_q.size() >= n), 32'd1);
   endtask

   task automatic waitDone(input string tag);
      int g = 0;
      while (init_done !== 1'b1 && g < 4000) begin
         applyStimulus();
         g++;
      end
      checkOutput(tag, 32'(init_done), 32'd1);
      checkRange({tag, "_gap"}, cyc - last_done_cyc, TPM * done_ms, TPM * done_ms + 4);
   endtask

   task automatic checkSequence(input logic check_gaps);
      checkOutput("seq_len", 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checkOutput($sformatf("byte%0d", i),
                     {22'd0, log_q[i].b, log_q[i].dc, log_q[i].cs},
                     {22'd0, exp_q[i].b, exp_q[i].dc, 1'b0});
         if (check_gaps) begin
            if (i == 0)
               checkRange("gap_first", log_q[0].cyc - rise_cyc, TPM * RWMS, TPM * RWMS + 4);
            else if (exp_q[i].gap_ms > 0)
               checkRange($sformatf("gap%0d", i), log_q[i].cyc - log_q[i-1].cyc,
                          TPM * exp_q[i].gap_ms, TPM * exp_q[i].gap_ms + wr_lat + 4);
            else
               checkRange($sformatf("gap%0d", i), log_q[i].cyc - log_q[i-1].cyc,
                          wr_lat + 1, wr_lat + 4);
         end
      end
   endtask

   // Directed sequence with randomized timing points.
   initial begin
      int n;
      int pend;
      int viol;
      logic [7:0] d0;

      for (int i = 0; i < 16; i++) tbl[i] = {2'b11, 8'h00};
      tbl[0] = {2'b00, 8'h01};  tbl[1] = {2'b10, 8'd120};
      tbl[2] = {2'b00, 8'h11};  tbl[3] = {2'b10, 8'd120};
      tbl[4] = {2'b00, 8'h3A};  tbl[5] = {2'b01, 8'h66};
      tbl[6] = {2'b00, 8'h36};  tbl[7] = {2'b01, 8'h48};
      tbl[8] = {2'b00, 8'h29};  tbl[9] = {2'b10, 8'd20};

      pend = 0;
      done_ms = 0;
      for (int i = 0; i < 16; i++) begin
         if (tbl[i][9:8] == 2'b11) begin
            done_ms = pend;
            break;
         end else if (tbl[i][9:8] == 2'b10) begin
            pend += int'(tbl[i][7:0]);
         end else begin
            exp_q.push_back('{tbl[i][7:0], tbl[i][8], pend});
            pend = 0;
         end
      end

      $display("[TB] run 1: full sequence, spurious done, backpressure");
      repeat (3) applyStimulus();
      checkReset("reset_hold");
      releaseReset(n);
      checkOutput("lcd_rst_low_cycles", 32'(n), 32'd40);

      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(20, 100)) applyStimulus();
         inject_done = 1'b1;
         applyStimulus();
         inject_done = 1'b0;
      end
      waitLog(1, "first_byte_seen");
      checkRange("first_sd_after_rst", log_q[0].cyc - rise_cyc, TPM * RWMS, TPM * RWMS + 4);
      checkOutput("first_byte", {22'd0, log_q[0].b, log_q[0].dc, log_q[0].cs},
                  {22'd0, 8'h01, 1'b0, 1'b0});

      for (int i = 0; i < 2; i++) begin
         repeat ($urandom_range(20, 150)) applyStimulus();
         inject_done = 1'b1;
         applyStimulus();
         inject_done = 1'b0;
      end
      waitLog(2, "second_byte_seen");
      checkRange("gap_01_11", log_q[1].cyc - log_q[0].cyc, TPM * RWMS, TPM * RWMS + wr_lat + 4);

      repeat (20) applyStimulus();
      hold_busy = 1'b1;
      n = 0;
      while (cs !== 1'b0 && n < 700) begin
         applyStimulus();
         n++;
      end
      checkOutput("bp_issue_reached", 32'(cs), 32'd0);
      d0 = data_out;
      viol = 0;
      for (int i = 0; i < 29; i++) begin
         applyStimulus();
         if (sd !== 1'b0 || cs !== 1'b0 || data_out !== d0) viol++;
      end
      checkOutput("bp_held", 32'(viol), 32'd0);
      hold_busy = 1'b0;
      applyStimulus();
      checkOutput("bp_sd_on_release", {23'd0, sd, data_out}, {23'd0, 1'b1, 8'h3A});
      applyStimulus();
      checkOutput("bp_sd_single", 32'(sd), 32'd0);

      waitDone("run1_done");
      checkSequence(1'b0);

      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         hold_busy   = 1'($urandom_range(0, 1));
         inject_done = 1'($urandom_range(0, 1));
         applyStimulus();
         if (sd !== 1'b0 || cs !== 1'b1 || init_done !== 1'b1) viol++;
      end
      hold_busy = 1'b0;
      inject_done = 1'b0;
      checkOutput("idle_after_done", 32'(viol), 32'd0);
      checkOutput("idle_no_bytes", 32'(log_q.size()), 32'(exp_q.size()));

      $display("[TB] run 2: resets mid-byte and mid-delay");
      resetDut("rst_from_done");
      releaseReset(n);
      checkOutput("lcd_rst_low_cycles_2", 32'(n), 32'd40);
      waitLog(3, "third_byte_seen");
      checkOutput("third_byte", {24'd0, log_q[2].b}, {24'd0, 8'h3A});
      repeat (2) applyStimulus();
      resetDut("rst_in_wait_done");
      releaseReset(n);
      waitLog(1, "restart1_seen");
      checkOutput("restart1_byte", {24'd0, log_q[0].b}, {24'd0, 8'h01});
      waitLog(2, "restart1_second_seen");
      repeat ($urandom_range(20, 400)) applyStimulus();
      resetDut("rst_in_delay");

      wr_lat = $urandom_range(1, 8);
      $display("[TB] run 3: clean sequence, writer latency %0d", wr_lat);
      releaseReset(n);
      checkOutput("lcd_rst_low_cycles_3", 32'(n), 32'd40);
      waitDone("run3_done");
      checkSequence(1'b1);

      checkOutput("sd_rules", 32'(viol_sd), 32'd0);
      checkOutput("lcd_rst_stays_high", 32'(viol_rst), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
